// File: rtl/ex_stage.sv
// ex_stage -- execute stage of a 5-stage in-order pipeline.
//
// This stage forwards operands, runs the ALU, and registers the result into
// the EX/MEM pipeline register. It also has an optional iterative
// shift-add multiplier.
//
// Optional feature: define EX_STAGE_MUL_EN to build the multiplier.
//   - Defined: an IDLE / MUL_BUSY / MUL_DONE FSM runs one shift-add step
//     per cycle. While it runs, stall holds the upstream stages.
//   - Undefined: MUL is single-cycle with result 0, and stall is tied low.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   ID_EX_*             decoded instruction: control bits, ALUOp, operands,
//                       immediate, destination index
//   ForwardA/B          operand select: 00/11 = register file,
//                       10 = EX/MEM result, 01 = WB data
//   WB_data             MEM/WB write-back value
//   flush               turns this cycle into a bubble and aborts any MUL
//   EX_MEM_*            registered control, result, store data and rd
//   stall               combinational; holds IF/ID/ID-EX while high
module ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUMBER = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ID_EX_valid,
  input  logic                  ID_EX_RegWrite,
  input  logic                  ID_EX_MemRead,
  input  logic                  ID_EX_MemWrite,
  input  logic                  ID_EX_MemToReg,
  input  logic                  ID_EX_ALUSrc,
  input  logic [3:0]            ID_EX_ALUOp,
  input  logic [DATA_WIDTH-1:0] ID_EX_rs1_data,
  input  logic [DATA_WIDTH-1:0] ID_EX_rs2_data,
  input  logic [DATA_WIDTH-1:0] ID_EX_imm,
  input  logic [REG_NUMBER-1:0] ID_EX_rd,
  input  logic [1:0]            ForwardA,
  input  logic [1:0]            ForwardB,
  input  logic [DATA_WIDTH-1:0] WB_data,
  input  logic                  flush,
  output logic                  EX_MEM_valid,
  output logic                  EX_MEM_RegWrite,
  output logic                  EX_MEM_MemRead,
  output logic                  EX_MEM_MemWrite,
  output logic                  EX_MEM_MemToReg,
  output logic [DATA_WIDTH-1:0] EX_MEM_ALUResult,
  output logic [DATA_WIDTH-1:0] EX_MEM_store_data,
  output logic [REG_NUMBER-1:0] EX_MEM_rd,
  output logic                  stall
);
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam logic [3:0] OP_MUL = 4'd9;

  logic [DATA_WIDTH-1:0] op_a, pre_b, alu_b, alu_res;
  logic                  is_mul;

  // Operand forwarding. The EX/MEM source is this stage's own output register.
  always_comb begin
    case (ForwardA)
      2'b10:   op_a = EX_MEM_ALUResult;
      2'b01:   op_a = WB_data;
      default: op_a = ID_EX_rs1_data;
    endcase
    case (ForwardB)
      2'b10:   pre_b = EX_MEM_ALUResult;
      2'b01:   pre_b = WB_data;
      default: pre_b = ID_EX_rs2_data;
    endcase
    alu_b = ID_EX_ALUSrc ? ID_EX_imm : pre_b;
  end

  always_comb begin
    case (ID_EX_ALUOp)
      4'd1:    alu_res = op_a - alu_b;
      4'd2:    alu_res = op_a & alu_b;
      4'd3:    alu_res = op_a | alu_b;
      4'd4:    alu_res = op_a ^ alu_b;
      4'd5:    alu_res = op_a << alu_b[SHW-1:0];
      4'd6:    alu_res = op_a >> alu_b[SHW-1:0];
      4'd7:    alu_res = $signed(op_a) >>> alu_b[SHW-1:0];
      4'd8:    alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(alu_b))};
      OP_MUL:  alu_res = '0;  // the iterative unit produces the real product
      default: alu_res = op_a + alu_b;
    endcase
  end

  assign is_mul = ID_EX_valid && (ID_EX_ALUOp == OP_MUL);

  // load_norm: capture the ALU result. load_mul: capture the product.
  // If neither is set, the stage issues a bubble.
  logic                  load_norm, load_mul;
  logic [DATA_WIDTH-1:0] mul_res;
  logic                  m_rw, m_mr, m_mw, m_mtr;
  logic [REG_NUMBER-1:0] m_rd;

`ifdef EX_STAGE_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_DONE} state_t;
  state_t          state, next_state;
  logic [SHW-1:0]  cnt;
  logic [DATA_WIDTH-1:0] mcand, mplier, prod;
  logic            mul_start;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (flush) next_state = IDLE;
    else begin
      case (state)
        IDLE:     if (is_mul) next_state = MUL_BUSY;
        MUL_BUSY: if (cnt == SHW'(DATA_WIDTH-1)) next_state = MUL_DONE;
        default:  next_state = IDLE;  // MUL_DONE never restarts the held MUL
      endcase
    end
  end

  always_comb begin
    mul_start = !flush && (state == IDLE) && is_mul;
    load_norm = !flush && (state == IDLE) && !is_mul;
    load_mul  = !flush && (state == MUL_DONE);
    // Gated by rst so that a reset presented with a MUL still waiting
    // does not report a stall.
    stall     = !rst && !flush && ((state == MUL_BUSY) || mul_start);
  end

  // Operands and control are captured at start. Later forwarding changes
  // cannot disturb a MUL that is already running.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0; mcand <= '0; mplier <= '0; prod <= '0;
      m_rw <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0; m_mtr <= 1'b0; m_rd <= '0;
    end else if (mul_start) begin
      cnt    <= '0;
      mcand  <= op_a;
      mplier <= alu_b;
      prod   <= '0;
      m_rw <= ID_EX_RegWrite; m_mr <= ID_EX_MemRead;
      m_mw <= ID_EX_MemWrite; m_mtr <= ID_EX_MemToReg; m_rd <= ID_EX_rd;
    end else if (!flush && state == MUL_BUSY) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + SHW'(1);
    end
  end

  assign mul_res = prod;
`else
  assign load_norm = !flush;
  assign load_mul  = 1'b0;
  assign stall     = 1'b0;
  assign mul_res   = '0;
  assign m_rw = 1'b0;
  assign m_mr = 1'b0;
  assign m_mw = 1'b0;
  assign m_mtr = 1'b0;
  assign m_rd = '0;
`endif

  // EX/MEM register. A bubble clears only the control bits; the data
  // fields keep their previous values.
  always_ff @(posedge clk) begin
    if (rst) begin
      EX_MEM_valid <= 1'b0; EX_MEM_RegWrite <= 1'b0; EX_MEM_MemRead <= 1'b0;
      EX_MEM_MemWrite <= 1'b0; EX_MEM_MemToReg <= 1'b0;
      EX_MEM_ALUResult <= '0; EX_MEM_store_data <= '0; EX_MEM_rd <= '0;
    end else if (load_norm) begin
      EX_MEM_valid      <= ID_EX_valid;
      EX_MEM_RegWrite   <= ID_EX_valid & ID_EX_RegWrite;
      EX_MEM_MemRead    <= ID_EX_valid & ID_EX_MemRead;
      EX_MEM_MemWrite   <= ID_EX_valid & ID_EX_MemWrite;
      EX_MEM_MemToReg   <= ID_EX_valid & ID_EX_MemToReg;
      EX_MEM_ALUResult  <= alu_res;
      EX_MEM_store_data <= pre_b;
      EX_MEM_rd         <= ID_EX_rd;
    end else if (load_mul) begin
      EX_MEM_valid      <= 1'b1;
      EX_MEM_RegWrite   <= m_rw;
      EX_MEM_MemRead    <= m_mr;
      EX_MEM_MemWrite   <= m_mw;
      EX_MEM_MemToReg   <= m_mtr;
      EX_MEM_ALUResult  <= mul_res;
      EX_MEM_rd         <= m_rd;
    end else begin
      EX_MEM_valid <= 1'b0; EX_MEM_RegWrite <= 1'b0; EX_MEM_MemRead <= 1'b0;
      EX_MEM_MemWrite <= 1'b0; EX_MEM_MemToReg <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage (DATA_WIDTH=32, REG_NUMBER=5).
// It applies a table of single-cycle vectors and checks each one through
// an expected-result queue. Hand-written sequences then cover flush,
// reset, and the MUL paths (multi-cycle when EX_STAGE_MUL_EN is defined).
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst;
  logic v, rw, mr, mw, mtr, src, flush;
  logic [3:0]  op;
  logic [31:0] rs1, rs2, imm, wb;
  logic [4:0]  rd;
  logic [1:0]  fa, fb;
  logic o_v, o_rw, o_mr, o_mw, o_mtr, stall;
  logic [31:0] o_res, o_st;
  logic [4:0]  o_rd;

  always #5 clk = ~clk;

  ex_stage #(.DATA_WIDTH(32), .REG_NUMBER(5)) dut (
    .clk(clk), .rst(rst),
    .ID_EX_valid(v), .ID_EX_RegWrite(rw), .ID_EX_MemRead(mr),
    .ID_EX_MemWrite(mw), .ID_EX_MemToReg(mtr), .ID_EX_ALUSrc(src),
    .ID_EX_ALUOp(op), .ID_EX_rs1_data(rs1), .ID_EX_rs2_data(rs2),
    .ID_EX_imm(imm), .ID_EX_rd(rd), .ForwardA(fa), .ForwardB(fb),
    .WB_data(wb), .flush(flush),
    .EX_MEM_valid(o_v), .EX_MEM_RegWrite(o_rw), .EX_MEM_MemRead(o_mr),
    .EX_MEM_MemWrite(o_mw), .EX_MEM_MemToReg(o_mtr),
    .EX_MEM_ALUResult(o_res), .EX_MEM_store_data(o_st), .EX_MEM_rd(o_rd),
    .stall(stall)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, imm, wb;
    logic        src;
    logic [1:0]  fa, fb;
    logic        v, rw, mr, mw, mtr;
    logic [4:0]  rd;
    logic [31:0] res, st;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t sb[$];
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    op = t.op; rs1 = t.a; rs2 = t.b; imm = t.imm; wb = t.wb; src = t.src;
    fa = t.fa; fb = t.fb; v = t.v; rw = t.rw; mr = t.mr; mw = t.mw;
    mtr = t.mtr; rd = t.rd;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(o_v), 32'd0);
    chk({tag, "_ctrl"}, {28'd0, o_rw, o_mr, o_mw, o_mtr}, 32'd0);
    chk({tag, "_res"}, o_res, 32'd0);
    chk({tag, "_st"}, o_st, 32'd0);
    chk({tag, "_rd"}, 32'(o_rd), 32'd0);
  endtask

  // Drive one single-cycle vector; the expected record rides the queue
  // and is compared once the EX/MEM register updates.
  task automatic run_vec(input vec_t t, input string tag);
    vec_t e;
    @(negedge clk);
    drive(t);
    sb.push_back(t);
    #1 chk({tag, "_stall"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, "_valid"}, 32'(o_v), 32'(e.v));
    chk({tag, "_ctrl"}, {28'd0, o_rw, o_mr, o_mw, o_mtr},
        {28'd0, e.v & e.rw, e.v & e.mr, e.v & e.mw, e.v & e.mtr});
    if (e.v) begin
      chk({tag, "_res"}, o_res, e.res);
      chk({tag, "_st"}, o_st, e.st);
      chk({tag, "_rd"}, 32'(o_rd), 32'(e.rd));
    end
  endtask

  function automatic vec_t alu(input logic [3:0] o, input logic [31:0] a, b,
                               input logic [4:0] d, input logic [31:0] res);
    vec_t t = '{op:o, a:a, b:b, imm:0, wb:0, src:0, fa:0, fb:0, v:1, rw:1,
                mr:0, mw:0, mtr:0, rd:d, res:res, st:b};
    return t;
  endfunction

`ifdef EX_STAGE_MUL_EN
  task automatic mul_seq(input logic [31:0] a, b, exp, input string tag);
    vec_t t;
    int stalls = 0, bubbles = 0;
    bit done = 0;
    t = alu(4'd9, a, b, 5'd7, exp);
    @(negedge clk);
    drive(t);
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (stall) begin
        stalls++;
        @(posedge clk); #1;
        if (!o_v && !o_rw) bubbles++;
        @(negedge clk);
        // A running MUL must keep the operands it captured at start.
        if (c == 3) begin rs1 = 32'h1234; rs2 = 32'h55; fa = 2'b01; wb = 32'h99; end
      end else begin
        @(posedge clk); #1;
        done = 1;
        chk({tag, "_res"}, o_res, exp);
        chk({tag, "_valid"}, 32'(o_v), 32'd1);
        chk({tag, "_rw"}, 32'(o_rw), 32'd1);
        chk({tag, "_rd"}, 32'(o_rd), 32'd7);
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_stalls"}, 32'(stalls), 32'd33);
    chk({tag, "_bubbles"}, 32'(bubbles), 32'd33);
    @(negedge clk);
    v = 1'b0; fa = 2'b00;
  endtask

  task automatic quiet(input int n, input string tag);
    int seen_v = 0, seen_s = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (o_v) seen_v++;
      if (stall) seen_s++;
    end
    chk({tag, "_no_result"}, 32'(seen_v), 32'd0);
    chk({tag, "_no_stall"}, 32'(seen_s), 32'd0);
  endtask
`endif

  initial begin
    rst = 1'b1; flush = 1'b0;
    drive(alu(4'd0, 0, 0, 0, 0));
    v = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    chk("reset_stall", 32'(stall), 32'd0);
    @(negedge clk) rst = 1'b0;

    // idx: op, a, b, rd, result
    tbl[0] = alu(4'd0, 5, 7, 1, 12);
    tbl[1] = alu(4'd1, 0, 2, 2, 10);                     tbl[1].fa = 2'b10;
    tbl[2] = alu(4'd0, 100, 0, 3, 104);                  tbl[2].fb = 2'b01;
    tbl[2].wb = 3; tbl[2].src = 1; tbl[2].imm = 4; tbl[2].st = 3;
    tbl[2].rw = 0; tbl[2].mw = 1;
    tbl[3] = alu(4'd7, 32'h80000000, 4, 4, 32'hF8000000);
    tbl[4] = alu(4'd8, 32'hFFFFFFFF, 1, 5, 1);
    tbl[5] = alu(4'd8, 1, 32'hFFFFFFFF, 6, 0);
    tbl[6] = alu(4'd6, 32'h80000000, 4, 7, 32'h08000000);
    tbl[7] = alu(4'd5, 1, 37, 8, 32);
    tbl[8] = alu(4'd2, 32'hF0F0, 32'hFF00, 9, 32'hF000);
    tbl[9] = alu(4'd3, 32'hF0F0, 32'hFF00, 10, 32'hFFF0);
    tbl[10] = alu(4'd4, 32'hF0F0, 32'hFF00, 11, 32'h0FF0);
    tbl[11] = alu(4'd0, 32'hFFFFFFFF, 1, 12, 0);
    tbl[12] = alu(4'd0, 1, 1, 13, 2);                    tbl[12].v = 0;
    tbl[13] = alu(4'd15, 3, 4, 14, 7);
    tbl[14] = alu(4'd0, 9, 1, 15, 10);                   tbl[14].fa = 2'b11;
    tbl[14].fb = 2'b11; tbl[14].wb = 32'hDEAD;
    tbl[15] = alu(4'd0, 32'h100, 0, 16, 32'h108);
    tbl[15].src = 1; tbl[15].imm = 8; tbl[15].mr = 1; tbl[15].mtr = 1;
    for (int i = 0; i < 16; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // A flush turns a valid ADD into a bubble.
    @(negedge clk);
    drive(alu(4'd0, 1, 2, 3, 3));
    flush = 1'b1;
    #1 chk("flush_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("flush_valid", 32'(o_v), 32'd0);
    chk("flush_rw", 32'(o_rw), 32'd0);
    @(negedge clk) flush = 1'b0; v = 1'b0;

`ifdef EX_STAGE_MUL_EN
    mul_seq(6, 7, 42, "mul6x7");
    mul_seq(32'hFFFFFFFF, 2, 32'hFFFFFFFE, "mulwrap");

    // Flush in the tenth MUL_BUSY cycle aborts the MUL.
    @(negedge clk);
    drive(alu(4'd9, 3, 5, 9, 15));
    repeat (10) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    #1 chk("mflush_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 chk("mflush_valid", 32'(o_v), 32'd0);
    flush = 1'b0;
    run_vec(alu(4'd0, 2, 3, 3, 5), "post_flush_add");
    @(negedge clk) v = 1'b0;
    quiet(40, "mflush");

    // Reset mid-MUL: outputs clear, and no result is ever delivered.
    @(negedge clk);
    drive(alu(4'd9, 6, 7, 4, 42));
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1 chk("mrst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 check_zero("mrst");
    @(negedge clk) rst = 1'b0; v = 1'b0;
    quiet(40, "mrst");
`else
    begin
      vec_t m = alu(4'd9, 6, 7, 17, 0);
      run_vec(m, "mul_nomul");
    end
    run_vec(alu(4'd0, 6, 7, 18, 13), "pre_rst");
    @(negedge clk) rst = 1'b1;
    #1 chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 check_zero("rst");
    @(negedge clk) rst = 1'b0; v = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
